// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: binary-to-BCD conversion and 4-digit common-anode 7-segment scan driver
// Ports: ACLK clock, ARESET async active-high reset, en_i display enable,
//   value_i/value_wr_i value to show and its write strobe, dp_i per-digit decimal point,
//   fnd_com active-low one-hot digit select, fnd_font active-low {dp,g..a} segments,
//   conv_busy conversion in progress, conv_done one-cycle buffer-updated pulse.
// Build option: define FND_LZB_EN for leading-zero blanking.
module fnd_scan_driver #(
  parameter int SCAN_DIV = 100000,
  parameter int VALUE_W = 14
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               en_i,
  input  logic [VALUE_W-1:0] value_i,
  input  logic               value_wr_i,
  input  logic [3:0]         dp_i,
  output logic [3:0]         fnd_com,
  output logic [7:0]         fnd_font,
  output logic               conv_busy,
  output logic               conv_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(VALUE_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [VALUE_W-1:0] sh, pend_val, start_val;
  logic [15:0] bcd, bcd_adj, disp;
  logic [IW-1:0] it;
  logic [CW-1:0] scnt;
  logic [1:0] idx;
  logic [3:0] nib;
  logic [7:0] seg, font_nx;
  logic pending, ovf, conv_ovf, start, blank;
  // A write arriving in DONE, or one parked while shifting, chains straight into SHIFT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = value_wr_i ? SHIFT : IDLE;
      SHIFT:   state_nx = (it == IW'(VALUE_W - 1)) ? DONE : SHIFT;
      DONE:    state_nx = (pending || value_wr_i) ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
    start = (state == IDLE && value_wr_i) || (state == DONE && (pending || value_wr_i));
    start_val = (state == DONE && !value_wr_i) ? pend_val : value_i;
  end
  genvar n;
  for (n = 0; n < 4; n++) begin : g_adj
    assign bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
  end
  assign conv_busy = state != IDLE;
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      sh <= '0;
      pend_val <= '0;
      bcd <= '0;
      it <= '0;
      pending <= 1'b0;
      conv_ovf <= 1'b0;
      ovf <= 1'b0;
      disp <= '0;
      conv_done <= 1'b0;
    end else begin
      state <= state_nx;
      conv_done <= state == DONE;
      if (start) begin
        sh <= start_val;
        bcd <= '0;
        it <= '0;
        conv_ovf <= 32'(start_val) > 32'd9999;
        pending <= 1'b0;
      end else begin
        if (state == SHIFT) begin
          bcd <= {bcd_adj[14:0], sh[VALUE_W-1]};
          sh <= sh << 1;
          it <= it + 1'b1;
        end
        if (value_wr_i) begin
          pending <= 1'b1;
          pend_val <= value_i;
        end
      end
      if (state == DONE) begin
        disp <= bcd;
        ovf <= conv_ovf;
      end
    end
  end
  always_comb begin
    nib = disp[4*idx +: 4];
    case (nib)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    seg = ovf ? 8'hBF : seg;
`ifdef FND_LZB_EN
    blank = !ovf && ((idx == 2'd3 && disp[15:12] == 4'd0) ||
                     (idx == 2'd2 && disp[15:8] == 8'd0) ||
                     (idx == 2'd1 && disp[15:4] == 12'd0));
`else
    blank = 1'b0;
`endif
    font_nx = (blank ? 8'hFF : seg) & ~{dp_i[idx], 7'b0};
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      scnt <= '0;
      idx <= '0;
      fnd_com <= 4'hF;
      fnd_font <= 8'hFF;
    end else begin
      scnt <= (!en_i || scnt == CW'(SCAN_DIV - 1)) ? '0 : scnt + 1'b1;
      idx <= !en_i ? 2'd0 : (scnt == CW'(SCAN_DIV - 1)) ? idx + 1'b1 : idx;
      fnd_com <= en_i ? ~(4'b1 << idx) : 4'hF;
      fnd_font <= en_i ? font_nx : 8'hFF;
    end
  end
endmodule
